// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU opcode codes, RV32I major opcodes and the funct3 -> ALU opcode map.
package alu_operand_stage_pkg;

    // RV32I major opcodes (inst[6:0]) handled by the integer ALU path.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU opcodes. Zero is reserved for "no operation" on illegal entries.
    localparam logic [5:0] ALU_OP_NONE            = 6'd0;
    localparam logic [5:0] ALU_OP_PLUS            = 6'd1;
    localparam logic [5:0] ALU_OP_SUB             = 6'd2;
    localparam logic [5:0] ALU_OP_SHIFT_LEFT      = 6'd3;
    localparam logic [5:0] ALU_OP_SET_LESS_THAN   = 6'd4;
    localparam logic [5:0] ALU_OP_SET_LESS_THAN_U = 6'd5;
    localparam logic [5:0] ALU_OP_XOR             = 6'd6;
    localparam logic [5:0] ALU_OP_SHIFT_RIGHT     = 6'd7;
    localparam logic [5:0] ALU_OP_SHIFT_RIGHT_A   = 6'd8;
    localparam logic [5:0] ALU_OP_OR              = 6'd9;
    localparam logic [5:0] ALU_OP_AND             = 6'd10;

    // funct3 map shared by OP and OP-IMM; b30 only selects SUB on the register form.
    function automatic logic [5:0] f3_to_alu_op(input logic [2:0] f3,
                                                input logic       b30,
                                                input logic       is_imm);
        case (f3)
            3'b000:  return (b30 && !is_imm) ? ALU_OP_SUB : ALU_OP_PLUS;
            3'b001:  return ALU_OP_SHIFT_LEFT;
            3'b010:  return ALU_OP_SET_LESS_THAN;
            3'b011:  return ALU_OP_SET_LESS_THAN_U;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return b30 ? ALU_OP_SHIFT_RIGHT_A : ALU_OP_SHIFT_RIGHT;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_stage_decode.sv
// Combinational ALU control decode: opcode selection and A/B operand conditioning.
module alu_ctrl_decode
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  illegal
);

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic                  b30;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;

    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign b30      = inst[30];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i    = DATA_WIDTH'($signed(inst[31:20]));
    assign imm_u    = DATA_WIDTH'($signed({inst[31:12], 12'b0}));

    // Select opcode and operands per instruction class; unknown classes flow as illegal.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op  = ALU_OP_NONE;
        A       = '0;
        B       = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                A      = rs1_data;
                B      = is_shift ? DATA_WIDTH'(rs2_data[4:0]) : rs2_data;
                alu_op = f3_to_alu_op(f3, b30, 1'b0);
            end
            OPC_OP_IMM: begin
                A      = rs1_data;
                B      = is_shift ? DATA_WIDTH'(inst[24:20]) : imm_i;
                alu_op = f3_to_alu_op(f3, b30, 1'b1);
            end
            OPC_LUI: begin
                B      = imm_u;
                alu_op = ALU_OP_PLUS;
            end
            OPC_AUIPC: begin
                A      = pc;
                B      = imm_u;
                alu_op = ALU_OP_PLUS;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand issue stage: one-entry output register with valid/ready handshake.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_E,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [4:0]            rd,
    output logic                  illegal
);

    logic [5:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_illegal;
    logic                  accept;

    alu_ctrl_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .inst     (inst),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pc       (pc),
        .alu_op   (dec_op),
        .A        (dec_a),
        .B        (dec_b),
        .illegal  (dec_illegal)
    );

    // The slot frees up whenever it is empty or being drained this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign alu_E    = out_valid & ~illegal;

    // Output register: reset > flush > accept > drain; data holds unless a new entry loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset too, since outputs must read 0 straight out of reset.
            out_valid <= 1'b0;
            alu_op    <= '0;
            alu_A     <= '0;
            alu_B     <= '0;
            rd        <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= dec_op;
            alu_A     <= dec_a;
            alu_B     <= dec_b;
            rd        <= inst[11:7];
            illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic        alu_E;
    logic [5:0]  alu_op;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [4:0]  rd;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_E     (alu_E),
        .alu_op    (alu_op),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .rd        (rd),
        .illegal   (illegal)
    );

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdi);
        return {f7, rs2, rs1, f3, rdi, OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rdi);
        return {imm, rs1, f3, rdi, OPC_OP_IMM};
    endfunction

    // Issue one instruction into an empty stage and compare the registered result.
    task automatic test_single(input string name, input logic [31:0] i,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] p, input logic [5:0] e_op,
                               input logic [31:0] e_a, input logic [31:0] e_b,
                               input logic [4:0] e_rd, input logic e_ill);
        logic [77:0] got, exp;
        @(negedge clk);
        in_valid = 1'b1; inst = i; rs1_data = r1; rs2_data = r2; pc = p; out_ready = 1'b1;
        @(posedge clk); #1;
        got = {out_valid, alu_E, alu_op, alu_A, alu_B, rd, illegal};
        exp = {1'b1, ~e_ill, e_op, e_a, e_b, e_rd, e_ill};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {valid,E,op,A,B,rd,ill} got %h expected %h", name, got, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [79:0] got, exp;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; rs1_data = '0; rs2_data = '0; pc = '0;
        exp = {1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        #1;
        got = {out_valid, alu_E, alu_op, alu_A, alu_B, rd, illegal, in_ready, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_during: got %h expected %h", got, exp);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        got = {out_valid, alu_E, alu_op, alu_A, alu_B, rd, illegal, in_ready, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_after: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_add_sub;
        test_single("sub", r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 32'h0,
                    ALU_OP_SUB, 32'd5, 32'd7, 5'd3, 1'b0);
        test_single("add", r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9), 32'd5, 32'd7, 32'h0,
                    ALU_OP_PLUS, 32'd5, 32'd7, 5'd9, 1'b0);
    endtask

    task automatic test_shift_mask;
        test_single("sra_mask", r_type(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd4), 32'h8000_0000,
                    32'h0000_0021, 32'h0, ALU_OP_SHIFT_RIGHT_A, 32'h8000_0000, 32'd1, 5'd4, 1'b0);
        test_single("srl_mask", r_type(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd4), 32'h0000_00F0,
                    32'hFFFF_FFE3, 32'h0, ALU_OP_SHIFT_RIGHT, 32'h0000_00F0, 32'd3, 5'd4, 1'b0);
        test_single("sll_mask", r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd6), 32'h1,
                    32'h0000_0105, 32'h0, ALU_OP_SHIFT_LEFT, 32'h1, 32'd5, 5'd6, 1'b0);
        test_single("srai_31", 32'h41F0_D093, 32'h0000_00F0, 32'h0000_DEAD, 32'h0,
                    ALU_OP_SHIFT_RIGHT_A, 32'h0000_00F0, 32'd31, 5'd1, 1'b0);
        test_single("slli", i_type(12'h005, 5'd1, 3'b001, 5'd2), 32'h0000_0003, 32'h0, 32'h0,
                    ALU_OP_SHIFT_LEFT, 32'h0000_0003, 32'd5, 5'd2, 1'b0);
    endtask

    task automatic test_logic;
        test_single("xor", r_type(7'b0, 5'd2, 5'd1, 3'b100, 5'd7), 32'hA, 32'hB, 32'h0,
                    ALU_OP_XOR, 32'hA, 32'hB, 5'd7, 1'b0);
        test_single("or", r_type(7'b0, 5'd2, 5'd1, 3'b110, 5'd8), 32'hC, 32'hD, 32'h0,
                    ALU_OP_OR, 32'hC, 32'hD, 5'd8, 1'b0);
        test_single("and", r_type(7'b0, 5'd2, 5'd1, 3'b111, 5'd10), 32'hE, 32'hF, 32'h0,
                    ALU_OP_AND, 32'hE, 32'hF, 5'd10, 1'b0);
        test_single("slt", r_type(7'b0, 5'd2, 5'd1, 3'b010, 5'd11), 32'hFFFF_FFFF, 32'h1, 32'h0,
                    ALU_OP_SET_LESS_THAN, 32'hFFFF_FFFF, 32'h1, 5'd11, 1'b0);
        test_single("sltu", r_type(7'b0, 5'd2, 5'd1, 3'b011, 5'd12), 32'h2, 32'h3, 32'h0,
                    ALU_OP_SET_LESS_THAN_U, 32'h2, 32'h3, 5'd12, 1'b0);
    endtask

    task automatic test_immediates;
        test_single("addi_800", i_type(12'h800, 5'd1, 3'b000, 5'd5), 32'h10, 32'h0, 32'h0,
                    ALU_OP_PLUS, 32'h10, 32'hFFFF_F800, 5'd5, 1'b0);
        test_single("addi_b30", i_type(12'hC00, 5'd1, 3'b000, 5'd5), 32'h10, 32'h0, 32'h0,
                    ALU_OP_PLUS, 32'h10, 32'hFFFF_FC00, 5'd5, 1'b0);
        test_single("sltiu_m1", i_type(12'hFFF, 5'd1, 3'b011, 5'd6), 32'h7, 32'h0, 32'h0,
                    ALU_OP_SET_LESS_THAN_U, 32'h7, 32'hFFFF_FFFF, 5'd6, 1'b0);
        test_single("andi", i_type(12'h0F0, 5'd1, 3'b111, 5'd6), 32'h7, 32'h0, 32'h0,
                    ALU_OP_AND, 32'h7, 32'h0000_00F0, 5'd6, 1'b0);
        test_single("lui", {20'h12345, 5'd13, OPC_LUI}, 32'hAAAA_AAAA, 32'h5555, 32'h200,
                    ALU_OP_PLUS, 32'h0, 32'h1234_5000, 5'd13, 1'b0);
        test_single("auipc", {20'h00001, 5'd14, OPC_AUIPC}, 32'hAAAA_AAAA, 32'h5555, 32'h100,
                    ALU_OP_PLUS, 32'h100, 32'h0000_1000, 5'd14, 1'b0);
    endtask

    task automatic test_illegal;
        test_single("load_illegal", 32'h0000_2083, 32'h5, 32'h6, 32'h100,
                    ALU_OP_NONE, 32'h0, 32'h0, 5'd1, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [38:0] got, exp;
        // First entry lands in the empty register while downstream is stalled.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        inst = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd4); rs1_data = 32'h11; rs2_data = 32'h22;
        @(posedge clk); #1;
        @(negedge clk);
        inst = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd5); rs1_data = 32'h33;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            got = {out_valid, in_ready, alu_A, rd};
            exp = {1'b1, 1'b0, 32'h11, 5'd4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_cycle%0d: {valid,in_ready,A,rd} got %h expected %h", c, got, exp);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        got = {out_valid, in_ready, alu_A, rd};
        exp = {1'b1, 1'b1, 32'h33, 5'd5};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", got, exp);
        end
        @(negedge clk);
        inst = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd6); rs1_data = 32'h44;
        @(posedge clk); #1;
        got = {out_valid, in_ready, alu_A, rd};
        exp = {1'b1, 1'b1, 32'h44, 5'd6};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_third: got %h expected %h", got, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush;
        logic [1:0] got;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        inst = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd7); rs1_data = 32'h55;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: out_valid got %b expected 1", out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1; flush = 1'b1;
        inst = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd8); rs1_data = 32'h66;
        @(posedge clk); #1;
        got = {out_valid, alu_E};
        checks++;
        if (got !== 2'b00) begin
            errors++;
            $display("FAIL flush_kill: {valid,E} got %b expected 00", got);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_input: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall;
        logic [79:0] got, exp;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        inst = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd9); rs1_data = 32'h77; rs2_data = 32'h88;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL stall_setup: {valid,in_ready} got %b expected 10", {out_valid, in_ready});
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        got = {out_valid, alu_E, alu_op, alu_A, alu_B, rd, illegal, in_ready, 1'b0};
        exp = {1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset_mid_stall: got %h expected %h", got, exp);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty: out_valid got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_mask();
        test_logic();
        test_immediates();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered decode/issue stage directly upstream of the integer basic ALU. It accepts one RV32I OP, OP-IMM, LUI or AUIPC instruction per cycle with its register-file operands and PC. It decodes the 6-bit ALU opcode, selects and conditions the A/B operands, and presents them from an output register. The outputs drive the ALU enable, opcode and A/B inputs. A valid/ready handshake with a one-entry output register lets writeback back-pressure the front end.

## Interface
- DATA_WIDTH, 32, operand/PC width; shift masking assumes 32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the held entry and of any same-cycle input.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  raw instruction word.
- rs1_data, rs2_data  in  DATA_WIDTH  register-file read data.
- pc  in  DATA_WIDTH  instruction address.
- out_valid  out  1  output register holds an entry.
- out_ready  in  1  downstream consumes this cycle.
- alu_E  out  1  ALU enable; equals out_valid & ~illegal.
- alu_op  out  6  ALU opcode, ALU_OP_* values.
- alu_A, alu_B  out  DATA_WIDTH  ALU operands.
- rd  out  5  destination register, inst[11:7].
- illegal  out  1  entry is not an ALU-class instruction.

## Operation
- Opcode inst[6:0]; f3 = inst[14:12]; b30 = inst[30].
- immI: sign-extended inst[31:20]. immU: {inst[31:12], 12'b0}.
- OP (0110011): A = rs1_data; B = rs2_data. For shifts, B = rs2_data & 31.
  - f3 000: SUB if b30, else PLUS.
  - 001: SHIFT_LEFT. 010: SET_LESS_THAN. 011: SET_LESS_THAN_U. 100: XOR.
  - 101: SHIFT_RIGHT_A if b30, else SHIFT_RIGHT.
  - 110: OR. 111: AND.
- OP-IMM (0010011): A = rs1_data; B = immI. Same f3 map, with these differences:
  - f3 000 is always PLUS; b30 is ignored.
  - Shifts use B = zero-extended inst[24:20].
  - SLTIU compares against the sign-extended immI, treated as unsigned.
- LUI (0110111): A = 0; B = immU; PLUS.
- AUIPC (0010111): A = pc; B = immU; PLUS.
- Any other opcode: illegal = 1, alu_op = 0, A = B = 0. The entry still flows so the trap logic sees it.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - Accept when in_valid & in_ready & ~flush.
  - Outputs hold stable while out_valid & ~out_ready.
- Priority: reset > flush > accept > hold.
  - Flush sets out_valid = 0 next cycle and drops any input offered that cycle.
  - Data registers may keep stale contents after flush; alu_E is 0.

## Timing
- Latency 1 cycle: an input accepted at edge N is visible on the outputs after edge N.
- Throughput 1 per cycle when out_ready stays high. Simultaneous consume and accept replaces the entry with no bubble.
- Reset (asynchronous assert): all outputs 0 (out_valid, alu_E, alu_op, alu_A, alu_B, rd, illegal). in_ready is 1 during and after reset.
- Reset mid-stall discards the held entry.
- No combinational path from in_valid or inst to any output. The only combinational path is out_ready to in_ready.

## Structure
- ALU_OP_* codes come from the shared ALU opcode header; RV32I major-opcode constants go in the same shared package/header.
- Combinational sub-module alu_ctrl_decode:
  - inputs: inst, rs1_data, rs2_data, pc;
  - outputs: alu_op, A, B, illegal.
- The top level holds the handshake and output register only.

## Test plan
- ADD/SUB: SUB x3,x1,x2 with rs1=5, rs2=7 → one cycle later alu_op=SUB, A=5, B=7, rd=3, alu_E=1.
- Shift masking:
  - SRA with rs2=0x00000021 → B=1, alu_op=SHIFT_RIGHT_A.
  - SRAI shamt 31 (inst 0x41F0D093) → B=31.
  - SLLI with b30=0 → SHIFT_LEFT.
- Immediates:
  - ADDI imm=0x800 → B=0xFFFFF800, PLUS (b30 set in imm field ignored).
  - LUI 0x12345 → A=0, B=0x12345000.
  - AUIPC at pc=0x100 → A=0x100.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. On release, back-to-back accepts with no lost or duplicated entries.
- Illegal/flush:
  - opcode 0000011 (load) → illegal=1, alu_E=0, out_valid=1.
  - flush with in_valid=1 → out_valid=0 next cycle.
- Reset: assert reset asynchronously mid-stall → all outputs 0 immediately, in_ready=1.
